// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble encoding and the IF/ID interlock state type.
package pipe_pkg;

  // All-ones instruction word marks an empty (bubble) pipeline slot.
  localparam logic [31:0] BUBBLE_IR = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones, never wraps.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step only when requested and not yet saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID pipeline register with load-use interlock: holds fetch and injects
// STALL_CYCLES bubbles per hazard, handles branch flush, freeze and bubble stats.
module if_id_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      IR_IF,
  input  logic             hasHazard,
  input  logic             flush,
  output logic [31:0]      IR_ID,
  output logic             pc_en,
  output logic             stalling,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Bubbles still owed after the one inserted on the hazard edge itself.
  localparam logic [3:0] RemInit = 4'(STALL_CYCLES - 1);
  localparam bit         MultiCycle = (STALL_CYCLES > 1);

  pipe_state_e state_q, state_d;
  logic [3:0]  remaining_q, remaining_d;
  logic [31:0] ir_id_q, ir_id_d;
  logic        stall_now;

  // A hazard bubble is inserted this cycle unless frozen or flushed.
  assign stall_now = en & ~flush &
                     (((state_q == ST_RUN) & hasHazard) | (state_q == ST_STALL));
  assign pc_en     = ~stall_now;
  assign stalling  = stall_now;
  assign IR_ID     = ir_id_q;

  // Next-state for the interlock FSM, stall countdown and IF/ID register.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ir_id_d     = ir_id_q;
    if (en) begin
      unique case (state_q)
        ST_RUN: begin
          if (flush) begin
            ir_id_d = BUBBLE_IR;
          end else if (hasHazard) begin
            ir_id_d = BUBBLE_IR;
            if (MultiCycle) begin
              state_d     = ST_STALL;
              remaining_d = RemInit;
            end
          end else begin
            ir_id_d = IR_IF;
          end
        end
        ST_STALL: begin
          // hasHazard is ignored here: the held instruction is already interlocked.
          ir_id_d = BUBBLE_IR;
          if (!flush && (remaining_q > 4'd1)) begin
            remaining_d = remaining_q - 4'd1;
          end else begin
            state_d     = ST_RUN;
            remaining_d = 4'd0;
          end
        end
        default: begin
          state_d     = ST_RUN;
          remaining_d = 4'd0;
        end
      endcase
    end
  end

  // State, countdown and IF/ID register; reset aborts any stall in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      remaining_q <= 4'd0;
      ir_id_q     <= BUBBLE_IR;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ir_id_q     <= ir_id_d;
    end
  end

  // Every hazard bubble (never a flush bubble) is counted.
  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stall_now),
    .q  (bubble_cnt)
  );

endmodule
